pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Control block that produces the freeze and flush strobes consumed by the IF/ID and ID/EX pipeline registers.
- Compares ID-stage source registers against EXE/MEM destinations and stalls on RAW hazards.
- Flushes younger stages on a taken branch resolved in EXE.
- Runs a req/ready handshake FSM that holds the whole pipeline during a multi-cycle SRAM access.
- Sits beside the pipeline registers in the core top level; outputs are pure control, with no datapath.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for sram_ready before the timeout error is flagged.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  async active-high reset.
- id_Rn  in  4  ID source register 1.
- id_Rm  in  4  ID source register 2.
- id_two_src  in  1  ID instruction reads Rm (register operand or store).
- id_use_Rn  in  1  ID instruction reads Rn (0 for MOV/MVN/B).
- exe_Dest  in  4  EXE destination register.
- exe_WB_EN  in  1  EXE writes back.
- exe_MEM_R_EN  in  1  EXE is a load.
- mem_Dest  in  4  MEM destination register.
- mem_WB_EN  in  1  MEM writes back.
- exe_B  in  1  taken branch in EXE.
- mem_R_EN  in  1  MEM-stage load.
- mem_W_EN  in  1  MEM-stage store.
- sram_ready  in  1  SRAM access complete (1-cycle pulse).
- sram_req  out  1  SRAM access request, held until ready.
- hazard_freeze  out  1  freeze PC and IF/ID; bubble into ID/EX.
- mem_freeze  out  1  freeze all pipeline registers.
- flush  out  1  flush IF/ID and ID/EX.
- sel_src1  out  2  forward select for Rn: 0 reg, 1 EXE/MEM result, 2 WB result.
- sel_src2  out  2  forward select for Rm, same encoding.
- mem_timeout  out  1  sticky timeout error.
- stall_cnt  out  CNT_W  count of cycles with any freeze asserted.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, sram_req=0, mem_timeout=0, stall_cnt=0, wait counter=0. The combinational outputs follow their equations with FSM=IDLE.
- Match definitions, with rdN meaning the ID source is actually read:
  - rn_hit_exe = id_use_Rn & exe_WB_EN & (id_Rn==exe_Dest)
  - rm_hit_exe = id_two_src & exe_WB_EN & (id_Rm==exe_Dest)
  - The same terms against the MEM stage are built from mem_WB_EN and mem_Dest.
- SRAM FSM:
  - IDLE: when (mem_R_EN|mem_W_EN), go to WAIT; sram_req=1.
  - WAIT: sram_req=1 and the wait counter increments. On sram_ready, go to DONE. When the counter reaches MEM_TIMEOUT-1 without ready, set mem_timeout=1 and stay in WAIT.
  - DONE: sram_req=0 and the counter clears. Return to IDLE next cycle, so the instruction that completed advances. A new request cannot start in the same cycle as DONE.
  - mem_freeze = (state==WAIT) | (state==IDLE & (mem_R_EN|mem_W_EN)). This makes the freeze zero-latency on the first request cycle.
  - sram_ready outside WAIT is ignored.
- flush = exe_B & ~mem_freeze. A branch under memory freeze is held in EXE, and its flush is deferred until the freeze releases, so the frozen branch is never squashed.
- hazard_freeze = raw_stall & ~flush & ~mem_freeze. On a taken branch the ID instruction is squashed, so no stall is needed.
- stall_cnt increments by 1 on each cycle with (hazard_freeze|mem_freeze) and wraps modulo 2^CNT_W.
- mem_timeout clears only on rst.
- Reset during WAIT aborts the access immediately, and sram_req drops asynchronously.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - raw_stall = exe_MEM_R_EN & (rn_hit_exe|rm_hit_exe), i.e. load-use hazards only.
  - sel_srcN = 1 on an EXE hit, else 2 on a MEM hit, else 0. The EXE hit has priority.
  - sel_srcN is forced to 0 when the corresponding read flag is 0.
- Undefined:
  - raw_stall = any of the four hit terms.
  - sel_src1 = sel_src2 = 0 constantly.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, WAIT, DONE).
  - Forward-select constants FWD_REG=0, FWD_EXE=1, FWD_WB=2.
  - Register-index width constant (4).
- One sub-module, sram_handshake_fsm, owns the FSM, wait counter and timeout flag.
- Hazard and forward comparison logic stays in the top module.

Test Plan:
- Macro off: id_Rn=3, id_use_Rn=1, exe_Dest=3, exe_WB_EN=1, exe_MEM_R_EN=0 -> hazard_freeze=1 the same cycle. The same case with FORWARDING_EN gives hazard_freeze=0 and sel_src1=1.
- FORWARDING_EN, load-use: exe_MEM_R_EN=1, exe_Dest=5, id_Rm=5, id_two_src=1 -> hazard_freeze=1. With id_two_src=0 -> hazard_freeze=0.
- SRAM access: mem_R_EN=1, sram_ready pulsed on wait cycle 4 -> mem_freeze=1 for 5 cycles, sram_req drops in DONE, stall_cnt increases by 5.
- Branch under freeze: exe_B=1 while FSM is in WAIT -> flush=0 until ready. flush=1 in the first cycle with mem_freeze=0, and hazard_freeze=0 in that cycle even with an RAW match.
- Timeout: mem_W_EN=1 and sram_ready never asserted, MEM_TIMEOUT=16 -> mem_timeout rises after 16 WAIT cycles and stays 1 until rst.
- Reset mid-WAIT: rst asserted at wait cycle 2 -> sram_req, mem_freeze, stall_cnt and mem_timeout are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the SRAM handshake states and forward-select encodings.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } sram_st_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline and the hazard controller.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_Rn;
    logic [REG_W-1:0] id_Rm;
    logic             id_two_src;
    logic             id_use_Rn;
    logic [REG_W-1:0] exe_Dest;
    logic             exe_WB_EN;
    logic             exe_MEM_R_EN;
    logic [REG_W-1:0] mem_Dest;
    logic             mem_WB_EN;
    logic             exe_B;
    logic             mem_R_EN;
    logic             mem_W_EN;
    logic             sram_ready;
    logic             sram_req;
    logic             hazard_freeze;
    logic             mem_freeze;
    logic             flush;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_Rn, id_Rm, id_two_src, id_use_Rn,
        output exe_Dest, exe_WB_EN, exe_MEM_R_EN,
        output mem_Dest, mem_WB_EN, exe_B,
        output mem_R_EN, mem_W_EN, sram_ready,
        input  sram_req, hazard_freeze, mem_freeze, flush,
        input  sel_src1, sel_src2, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_Rn, id_Rm, id_two_src, id_use_Rn,
        input  exe_Dest, exe_WB_EN, exe_MEM_R_EN,
        input  mem_Dest, mem_WB_EN, exe_B,
        input  mem_R_EN, mem_W_EN, sram_ready,
        output sram_req, hazard_freeze, mem_freeze, flush,
        output sel_src1, sel_src2, mem_timeout, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sram_handshake_fsm.sv
// SRAM req/ready handshake: holds the pipeline while an access is pending.
// Flags a sticky timeout if ready does not arrive in MEM_TIMEOUT wait cycles.
module sram_handshake_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_ready,
    output logic o_sram_req,
    output logic o_mem_freeze,
    output logic o_timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] CMAX = CW'(MEM_TIMEOUT - 1);

    sram_st_e      r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req;
    logic          r_to;

    // Freeze starts in the request cycle itself, before WAIT is entered.
    assign o_mem_freeze = (r_state == WAIT) | ((r_state == IDLE) & i_req);
    assign o_sram_req   = r_req;
    assign o_timeout    = r_to;

    // State, wait counter, request strobe and sticky timeout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (i_ready) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                    end else if (r_cnt == CMAX) begin
                        r_to <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_req   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall, branch flush, SRAM freeze.
// Build option FORWARDING_EN: stall only on load-use and drive forward selects.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    logic             w_rn_hit_exe;
    logic             w_rm_hit_exe;
    logic             w_rn_hit_mem;
    logic             w_rm_hit_mem;
    logic             w_raw_stall;
    logic             w_mem_freeze;
    logic             w_flush;
    logic             w_hazard_freeze;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_rn_hit_exe = bus.id_use_Rn & bus.exe_WB_EN & (bus.id_Rn == bus.exe_Dest);
    assign w_rm_hit_exe = bus.id_two_src & bus.exe_WB_EN & (bus.id_Rm == bus.exe_Dest);
    assign w_rn_hit_mem = bus.id_use_Rn & bus.mem_WB_EN & (bus.id_Rn == bus.mem_Dest);
    assign w_rm_hit_mem = bus.id_two_src & bus.mem_WB_EN & (bus.id_Rm == bus.mem_Dest);

`ifdef FORWARDING_EN
    assign w_raw_stall = bus.exe_MEM_R_EN & (w_rn_hit_exe | w_rm_hit_exe);
    // Hit terms already include the read flags, so unread sources stay FWD_REG.
    assign bus.sel_src1 = w_rn_hit_exe ? FWD_EXE :
                          w_rn_hit_mem ? FWD_WB  : FWD_REG;
    assign bus.sel_src2 = w_rm_hit_exe ? FWD_EXE :
                          w_rm_hit_mem ? FWD_WB  : FWD_REG;
`else
    logic w_unused_ld;
    assign w_unused_ld = bus.exe_MEM_R_EN;
    assign w_raw_stall = w_rn_hit_exe | w_rm_hit_exe | w_rn_hit_mem | w_rm_hit_mem;
    assign bus.sel_src1 = FWD_REG;
    assign bus.sel_src2 = FWD_REG;
`endif

    sram_handshake_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (bus.mem_R_EN | bus.mem_W_EN),
        .i_ready      (bus.sram_ready),
        .o_sram_req   (bus.sram_req),
        .o_mem_freeze (w_mem_freeze),
        .o_timeout    (bus.mem_timeout)
    );

    // A frozen branch stays in EXE; its flush waits for the freeze to lift.
    assign w_flush         = bus.exe_B & ~w_mem_freeze;
    assign w_hazard_freeze = w_raw_stall & ~w_flush & ~w_mem_freeze;

    assign bus.mem_freeze    = w_mem_freeze;
    assign bus.flush         = w_flush;
    assign bus.hazard_freeze = w_hazard_freeze;
    assign bus.stall_cnt     = r_stall_cnt;

    // Count every cycle in which any part of the pipeline is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard_freeze | w_mem_freeze) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Vector table for the hazard/forward logic plus SRAM handshake sequences.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bif ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rn;
        logic [3:0] rm;
        logic       two;
        logic       use_rn;
        logic [3:0] exd;
        logic       exwb;
        logic       exld;
        logic [3:0] md;
        logic       mwb;
        logic       br;
        logic       hf_nf;
        logic       hf_f;
        logic [1:0] s1_f;
        logic [1:0] s2_f;
        logic       fl;
    } vec_t;

    vec_t vt [10];
    vec_t exp_q [$];

    int n_pass = 0;
    int n_total = 0;
    int stall_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        bif.id_Rn = 4'd0;
        bif.id_Rm = 4'd0;
        bif.id_two_src = 1'b0;
        bif.id_use_Rn = 1'b0;
        bif.exe_Dest = 4'd15;
        bif.exe_WB_EN = 1'b0;
        bif.exe_MEM_R_EN = 1'b0;
        bif.mem_Dest = 4'd14;
        bif.mem_WB_EN = 1'b0;
        bif.exe_B = 1'b0;
        bif.mem_R_EN = 1'b0;
        bif.mem_W_EN = 1'b0;
        bif.sram_ready = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        bif.id_Rn = v.rn;
        bif.id_Rm = v.rm;
        bif.id_two_src = v.two;
        bif.id_use_Rn = v.use_rn;
        bif.exe_Dest = v.exd;
        bif.exe_WB_EN = v.exwb;
        bif.exe_MEM_R_EN = v.exld;
        bif.mem_Dest = v.md;
        bif.mem_WB_EN = v.mwb;
        bif.exe_B = v.br;
    endtask

    initial begin
        vec_t e;
        logic       ehf;
        logic [1:0] es1;
        logic [1:0] es2;

        //        rn    rm    two   use   exd   exwb  exld  md    mwb   br    hfnf  hf_f  s1    s2    fl
        vt[0] = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0};
        vt[1] = '{4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
        vt[2] = '{4'd1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[3] = '{4'd7, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0};
        vt[4] = '{4'd2, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0};
        vt[5] = '{4'd4, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[6] = '{4'd4, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[7] = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1};
        vt[8] = '{4'd0, 4'd9, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0};
        vt[9] = '{4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

        idle_inputs();
        #1;
        chk("rst_sram_req", 32'(bif.sram_req), 32'd0);
        chk("rst_mem_freeze", 32'(bif.mem_freeze), 32'd0);
        chk("rst_timeout", 32'(bif.mem_timeout), 32'd0);
        chk("rst_stall_cnt", bif.stall_cnt, 32'd0);
        chk("rst_flush", 32'(bif.flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hazard / forward vectors, one clock each.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            drive_vec(vt[i]);
            exp_q.push_back(vt[i]);
            @(negedge clk);
            e = exp_q.pop_front();
`ifdef FORWARDING_EN
            ehf = e.hf_f;
            es1 = e.s1_f;
            es2 = e.s2_f;
`else
            ehf = e.hf_nf;
            es1 = 2'd0;
            es2 = 2'd0;
`endif
            chk($sformatf("v%0d_hazard_freeze", i), 32'(bif.hazard_freeze), 32'(ehf));
            chk($sformatf("v%0d_flush", i), 32'(bif.flush), 32'(e.fl));
            chk($sformatf("v%0d_sel_src1", i), 32'(bif.sel_src1), 32'(es1));
            chk($sformatf("v%0d_sel_src2", i), 32'(bif.sel_src2), 32'(es2));
            chk($sformatf("v%0d_mem_freeze", i), 32'(bif.mem_freeze), 32'd0);
            stall_exp += int'(ehf);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        chk("table_stall_cnt", bif.stall_cnt, 32'(stall_exp));

        // SRAM read, ready on wait cycle 4.
        @(posedge clk);
        #1;
        bif.mem_R_EN = 1'b1;
        @(negedge clk);
        chk("rd_idle_freeze", 32'(bif.mem_freeze), 32'd1);
        chk("rd_idle_req", 32'(bif.sram_req), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("rd_w%0d_freeze", k), 32'(bif.mem_freeze), 32'd1);
            chk($sformatf("rd_w%0d_req", k), 32'(bif.sram_req), 32'd1);
            if (k == 4) bif.sram_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bif.sram_ready = 1'b0;
        bif.mem_R_EN = 1'b0;
        stall_exp += 5;
        @(negedge clk);
        chk("rd_done_req", 32'(bif.sram_req), 32'd0);
        chk("rd_done_freeze", 32'(bif.mem_freeze), 32'd0);
        chk("rd_stall_cnt", bif.stall_cnt, 32'(stall_exp));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_back_idle_freeze", 32'(bif.mem_freeze), 32'd0);

        // Taken branch with a RAW match while the store is pending.
        @(posedge clk);
        #1;
        bif.mem_W_EN = 1'b1;
        bif.exe_B = 1'b1;
        bif.id_Rn = 4'd3;
        bif.id_use_Rn = 1'b1;
        bif.exe_Dest = 4'd3;
        bif.exe_WB_EN = 1'b1;
        bif.exe_MEM_R_EN = 1'b1;
        @(negedge clk);
        chk("br_idle_flush", 32'(bif.flush), 32'd0);
        chk("br_idle_hf", 32'(bif.hazard_freeze), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("br_w%0d_flush", k), 32'(bif.flush), 32'd0);
            chk($sformatf("br_w%0d_hf", k), 32'(bif.hazard_freeze), 32'd0);
            if (k == 3) bif.sram_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bif.sram_ready = 1'b0;
        bif.mem_W_EN = 1'b0;
        stall_exp += 4;
        @(negedge clk);
        chk("br_done_flush", 32'(bif.flush), 32'd1);
        chk("br_done_hf", 32'(bif.hazard_freeze), 32'd0);
        chk("br_done_freeze", 32'(bif.mem_freeze), 32'd0);
        chk("br_stall_cnt", bif.stall_cnt, 32'(stall_exp));
        @(posedge clk);
        #1;
        idle_inputs();

        // Store with no ready: timeout after 16 wait cycles.
        @(posedge clk);
        #1;
        bif.mem_W_EN = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (k == 1) chk("to_w1_timeout", 32'(bif.mem_timeout), 32'd0);
            if (k == 16) chk("to_w16_timeout", 32'(bif.mem_timeout), 32'd0);
        end
        for (int k = 17; k <= 20; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("to_w%0d_timeout", k), 32'(bif.mem_timeout), 32'd1);
            chk($sformatf("to_w%0d_freeze", k), 32'(bif.mem_freeze), 32'd1);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        bif.mem_W_EN = 1'b0;
        #1;
        chk("to_rst_timeout", 32'(bif.mem_timeout), 32'd0);
        chk("to_rst_req", 32'(bif.sram_req), 32'd0);
        chk("to_rst_stall", bif.stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a wait, no clock edge involved.
        @(posedge clk);
        #1;
        bif.mem_R_EN = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mr_w2_req", 32'(bif.sram_req), 32'd1);
        chk("mr_w2_stall", bif.stall_cnt, 32'd2);
        #1;
        rst = 1'b1;
        bif.mem_R_EN = 1'b0;
        #1;
        chk("mr_rst_req", 32'(bif.sram_req), 32'd0);
        chk("mr_rst_freeze", 32'(bif.mem_freeze), 32'd0);
        chk("mr_rst_stall", bif.stall_cnt, 32'd0);
        chk("mr_rst_timeout", 32'(bif.mem_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
